// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: 2^INDEX_BITS lines of 128-bit blocks,
// single-block fills from instruction memory, saturating hit/miss counters.
module icache_controller #(
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cpu_read,
    input  logic [9:0]           address,
    output logic [31:0]          instruction,
    output logic                 busywait,
    output logic                 mem_read,
    output logic [5:0]           mem_address,
    input  logic [127:0]         mem_readdata,
    input  logic                 mem_busywait,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int unsigned TagBits  = 6 - INDEX_BITS;
    localparam int unsigned NumLines = 1 << INDEX_BITS;
    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StMemRead = 2'd1,
        StUpdate  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [5:0]             fill_addr_q, fill_addr_d;
    logic                   mem_read_q, mem_read_d;
    logic [CNT_WIDTH-1:0]   hit_count_q, hit_count_d;
    logic [CNT_WIDTH-1:0]   miss_count_q, miss_count_d;
    logic [NumLines-1:0]    valid_q, valid_d;

    logic [3:0][31:0]       data_q [NumLines];
    logic [3:0][31:0]       data_d [NumLines];
    logic [TagBits-1:0]     tag_q  [NumLines];
    logic [TagBits-1:0]     tag_d  [NumLines];

    logic [INDEX_BITS-1:0]  index;
    logic [TagBits-1:0]     tag;
    logic [INDEX_BITS-1:0]  fill_index;
    logic [TagBits-1:0]     fill_tag;
    logic                   hit;
    logic                   fill_en;

    assign index      = address[INDEX_BITS+3:4];
    assign tag        = address[9:INDEX_BITS+4];
    assign fill_index = fill_addr_q[INDEX_BITS-1:0];
    assign fill_tag   = fill_addr_q[5:INDEX_BITS];
    assign hit        = valid_q[index] && (tag_q[index] == tag);
    assign fill_en    = (state_q == StUpdate);

    assign instruction = data_q[index][address[3:2]];
    assign mem_read    = mem_read_q;
    assign mem_address = fill_addr_q;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;

    // Gated by reset so the stall drops immediately while reset is held, even with a
    // pending cpu_read against the freshly invalidated cache.
    always_comb begin
        busywait = 1'b0;
        if (reset) begin
            busywait = (state_q != StIdle) || (cpu_read && !hit);
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_addr_d  = fill_addr_q;
        mem_read_d   = mem_read_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        valid_d      = valid_q;
        unique case (state_q)
            StIdle: begin
                mem_read_d = 1'b0;
                if (cpu_read) begin
                    if (hit) begin
                        if (hit_count_q != CntMax) hit_count_d = hit_count_q + CntOne;
                    end else begin
                        fill_addr_d = address[9:4];
                        if (miss_count_q != CntMax) miss_count_d = miss_count_q + CntOne;
                        mem_read_d  = 1'b1;
                        state_d     = StMemRead;
                    end
                end
            end
            StMemRead: begin
                if (!mem_busywait) begin
                    mem_read_d = 1'b0;
                    state_d    = StUpdate;
                end
            end
            StUpdate: begin
                valid_d[fill_index] = 1'b1;
                mem_read_d          = 1'b0;
                state_d             = StIdle;
            end
            default: begin
                mem_read_d = 1'b0;
                state_d    = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            fill_addr_q  <= 6'd0;
            mem_read_q   <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            fill_addr_q  <= fill_addr_d;
            mem_read_q   <= mem_read_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            valid_q      <= valid_d;
        end
    end

    // Line storage needs no reset: valid bits gate every use of it.
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        if (fill_en) begin
            data_d[fill_index] = mem_readdata;
            tag_d[fill_index]  = fill_tag;
        end
    end

    always_ff @(posedge clock) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

endmodule

// File: tb/tb_icache_controller.sv
// Bench for icache_controller: directed table, hand-written fill/reset sequences,
// randomized reads against a block-level cache model, and a narrow-counter instance.
module tb_icache_controller;

    logic         clock;
    logic         reset;
    logic         cpu_read;
    logic [9:0]   address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    logic         cpu_read_s;
    logic [9:0]   address_s;
    logic [31:0]  instruction_s;
    logic         busywait_s;
    logic         mem_read_s;
    logic [5:0]   mem_address_s;
    logic [127:0] mem_readdata_s;
    logic         mem_busywait_s;
    logic [3:0]   hit_count_s;
    logic [3:0]   miss_count_s;

    icache_controller #(.INDEX_BITS(3), .CNT_WIDTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_read     (cpu_read),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    icache_controller #(.INDEX_BITS(3), .CNT_WIDTH(4)) dut_sat (
        .clock        (clock),
        .reset        (reset),
        .cpu_read     (cpu_read_s),
        .address      (address_s),
        .instruction  (instruction_s),
        .busywait     (busywait_s),
        .mem_read     (mem_read_s),
        .mem_address  (mem_address_s),
        .mem_readdata (mem_readdata_s),
        .mem_busywait (mem_busywait_s),
        .hit_count    (hit_count_s),
        .miss_count   (miss_count_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory responder: busy for mem_lat cycles of an asserted read, data always valid.
    logic [127:0] mem_blocks [64];
    int unsigned  mem_lat = 0;
    int unsigned  mem_cnt = 0;
    assign mem_readdata   = mem_blocks[mem_address];
    assign mem_busywait   = mem_read && (mem_cnt < mem_lat);
    assign mem_readdata_s = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    assign mem_busywait_s = 1'b0;
    always @(posedge clock) mem_cnt <= mem_read ? mem_cnt + 1 : 0;

    // Model: which memory block each line holds; contents follow from memory itself.
    bit          mvalid [8];
    logic [5:0]  mblk   [8];
    int unsigned m_hits;
    int unsigned m_misses;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        logic [127:0] blk;
        blk = mem_blocks[a[9:4]];
        return blk[32*a[3:2] +: 32];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic do_read(input logic [9:0] a, input int lat, input bit chg,
                           output bit got_miss, output logic [31:0] got_instr,
                           output int unsigned hc0, output int unsigned mc0);
        bit         exp_hit;
        int         cycles;
        logic [2:0] idx;
        @(posedge clock); #1;
        cpu_read = 1'b1;
        address  = a;
        mem_lat  = lat;
        #1;
        hc0 = hit_count;
        mc0 = miss_count;
        chk("hit_count", 32'(hit_count), m_hits);
        chk("miss_count", 32'(miss_count), m_misses);
        idx      = a[6:4];
        exp_hit  = mvalid[idx] && (mblk[idx] == a[9:4]);
        got_miss = busywait;
        chk("busywait_lookup", 32'(busywait), 32'(!exp_hit));
        if (exp_hit) begin
            chk("mem_read_on_hit", 32'(mem_read), 32'd0);
        end else begin
            m_misses++;
            cycles = 0;
            while (busywait && cycles < 40) begin
                @(posedge clock); #1;
                if (chg) address = mem_read ? 10'($urandom_range(0, 1023)) : a;
                #1;
                cycles++;
                if (busywait) begin
                    if (cycles <= lat + 1) begin
                        chk("mem_read_fill", 32'(mem_read), 32'd1);
                        chk("mem_address", 32'(mem_address), 32'(a[9:4]));
                    end else begin
                        chk("mem_read_update", 32'(mem_read), 32'd0);
                    end
                end
            end
            chk("miss_penalty", 32'(cycles), 32'(lat + 3));
            chk("mem_read_idle", 32'(mem_read), 32'd0);
            mvalid[idx] = 1'b1;
            mblk[idx]   = a[9:4];
        end
        got_instr = instruction;
        chk("instruction", instruction, mem_word(a));
        m_hits++;
    endtask

    typedef struct {
        logic [9:0]  addr;
        int          lat;
        bit          miss;
        logic [31:0] instr;
        int unsigned hc0;
        int unsigned mc0;
    } vec_t;

    vec_t        vecs [6];
    bit          got_miss;
    logic [31:0] got_instr;
    int unsigned hc0;
    int unsigned mc0;
    int          cycles;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) begin
            mem_blocks[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        mem_blocks[0] = {32'h0A000103, 32'h00010031, 32'h00040021, 32'h00030014};
        mem_blocks[8] = {32'h88888883, 32'h88888882, 32'h88888881, 32'h88888880};

        vecs[0] = '{10'h000, 2, 1'b1, 32'h00030014, 0, 0};
        vecs[1] = '{10'h004, 0, 1'b0, 32'h00040021, 1, 1};
        vecs[2] = '{10'h008, 0, 1'b0, 32'h00010031, 2, 1};
        vecs[3] = '{10'h00C, 0, 1'b0, 32'h0A000103, 3, 1};
        vecs[4] = '{10'h080, 1, 1'b1, 32'h88888880, 4, 1};
        vecs[5] = '{10'h000, 0, 1'b1, 32'h00030014, 5, 2};

        reset      = 1'b0;
        cpu_read   = 1'b0;
        address    = 10'd0;
        cpu_read_s = 1'b0;
        address_s  = 10'd0;
        model_reset();
        #2;
        chk("reset_busywait", 32'(busywait), 32'd0);
        chk("reset_mem_read", 32'(mem_read), 32'd0);
        chk("reset_mem_address", 32'(mem_address), 32'd0);
        chk("reset_hit_count", 32'(hit_count), 32'd0);
        chk("reset_miss_count", 32'(miss_count), 32'd0);
        #21;
        reset = 1'b1;

        // Cold miss, hits in the same block, then conflict misses on line 0.
        for (int i = 0; i < 6; i++) begin
            do_read(vecs[i].addr, vecs[i].lat, 1'b0, got_miss, got_instr, hc0, mc0);
            chk("vec_miss", 32'(got_miss), 32'(vecs[i].miss));
            chk("vec_instr", got_instr, vecs[i].instr);
            chk("vec_hit_count", hc0, vecs[i].hc0);
            chk("vec_miss_count", mc0, vecs[i].mc0);
        end

        // cpu_read dropped while the fill is in progress.
        @(posedge clock); #1;
        cpu_read = 1'b1;
        address  = 10'h010;
        mem_lat  = 3;
        #1;
        chk("drop_busywait", 32'(busywait), 32'd1);
        m_misses++;
        @(posedge clock); #1;
        cpu_read = 1'b0;
        #1;
        chk("drop_mem_read", 32'(mem_read), 32'd1);
        chk("drop_busywait_held", 32'(busywait), 32'd1);
        cycles = 1;
        while (busywait && cycles < 40) begin
            @(posedge clock); #2;
            cycles++;
            if (busywait && cycles <= 4) chk("drop_mem_read_held", 32'(mem_read), 32'd1);
        end
        chk("drop_penalty", 32'(cycles), 32'd6);
        mvalid[1] = 1'b1;
        mblk[1]   = 6'h01;
        do_read(10'h014, 0, 1'b0, got_miss, got_instr, hc0, mc0);
        chk("drop_then_hit", 32'(got_miss), 32'd0);

        // Reset pulled during MEM_READ.
        @(posedge clock); #1;
        cpu_read = 1'b1;
        address  = 10'h020;
        mem_lat  = 5;
        #1;
        chk("rst_mid_lookup", 32'(busywait), 32'd1);
        @(posedge clock); #1;
        chk("rst_mid_mem_read", 32'(mem_read), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_mem_read_low", 32'(mem_read), 32'd0);
        chk("rst_mid_busywait", 32'(busywait), 32'd0);
        chk("rst_mid_hit_count", 32'(hit_count), 32'd0);
        chk("rst_mid_miss_count", 32'(miss_count), 32'd0);
        model_reset();
        @(posedge clock); #3;
        cpu_read = 1'b0;
        reset    = 1'b1;
        do_read(10'h004, 1, 1'b0, got_miss, got_instr, hc0, mc0);
        chk("post_reset_miss", 32'(got_miss), 32'd1);

        // Randomized reads over a small block pool, with idle gaps and address churn.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clock); #1;
                cpu_read = 1'b0;
                address  = 10'($urandom_range(0, 1023));
                #1;
                chk("idle_busywait", 32'(busywait), 32'd0);
                chk("idle_mem_read", 32'(mem_read), 32'd0);
            end
            do_read({6'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00},
                    int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                    got_miss, got_instr, hc0, mc0);
        end
        @(posedge clock); #1;
        cpu_read = 1'b0;
        #1;
        chk("final_hit_count", 32'(hit_count), m_hits);
        chk("final_miss_count", 32'(miss_count), m_misses);

        // Narrow counter saturation: miss, fill, then continuous hits on one address.
        @(posedge clock); #1;
        cpu_read_s = 1'b1;
        address_s  = 10'h000;
        repeat (10) @(posedge clock);
        #1;
        chk("sat_hit_count_mid", 32'(hit_count_s), 32'd7);
        chk("sat_miss_count", 32'(miss_count_s), 32'd1);
        chk("sat_instruction", instruction_s, 32'hA0A0A0A0);
        repeat (15) @(posedge clock);
        #1;
        chk("sat_hit_count_max", 32'(hit_count_s), 32'hF);
        repeat (5) @(posedge clock);
        #1;
        chk("sat_hit_count_hold", 32'(hit_count_s), 32'hF);
        cpu_read_s = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
